sha256_block_acc: RTL and testbench

Memory-mapped SHA-256 compression accelerator for the mining datapath. Software writes one pre-padded 512-bit message block as sixteen 32-bit words, triggers a start, and the block runs the 64-round SHA-256 compression from the standard IV. It then streams the eight 32-bit digest words out on a word/index port toward the downstream result memory.

---
 rtl/sha256_pkg.sv | 53 +++++
 rtl/sha256_round.sv | 30 +++
 rtl/sha256_block_acc.sv | 125 ++++++++++++
 tb/tb_sha256_block_acc.sv | 229 ++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
// rtl/sha256_pkg.sv - SHA-256 constants, FSM state type and round helper functions
package sha256_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LOAD,
        S_ROUND,
        S_FINAL,
        S_OUT,
        S_DONE
    } state_t;

    localparam logic [31:0] K [0:63] = '{
        32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
        32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
        32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
        32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
        32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
        32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
        32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
        32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
    };

    localparam logic [31:0] IV [0:7] = '{
        32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
        32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
    };

    function automatic logic [31:0] big_sigma0(input logic [31:0] x);
        return {x[1:0], x[31:2]} ^ {x[12:0], x[31:13]} ^ {x[21:0], x[31:22]};
    endfunction

    function automatic logic [31:0] big_sigma1(input logic [31:0] x);
        return {x[5:0], x[31:6]} ^ {x[10:0], x[31:11]} ^ {x[24:0], x[31:25]};
    endfunction

    function automatic logic [31:0] small_sigma0(input logic [31:0] x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ {3'b000, x[31:3]};
    endfunction

    function automatic logic [31:0] small_sigma1(input logic [31:0] x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ {10'b0, x[31:10]};
    endfunction

    function automatic logic [31:0] ch(input logic [31:0] e, input logic [31:0] f, input logic [31:0] g);
        return (e & f) ^ (~e & g);
    endfunction

    function automatic logic [31:0] maj(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
        return (a & b) ^ (a & c) ^ (b & c);
    endfunction

endpackage

// File: rtl/sha256_round.sv
// rtl/sha256_round.sv - combinational single SHA-256 compression round
//   st_in[0:7]  : working variables a..h before the round
//   k, w        : round constant K[t] and schedule word W[t]
//   st_out[0:7] : working variables a..h after the round
module sha256_round
    import sha256_pkg::*;
(
    input  logic [31:0] st_in  [0:7],
    input  logic [31:0] k,
    input  logic [31:0] w,
    output logic [31:0] st_out [0:7]
);

    logic [31:0] t1;
    logic [31:0] t2;

    always_comb begin
        t1 = st_in[7] + big_sigma1(st_in[4]) + ch(st_in[4], st_in[5], st_in[6]) + k + w;
        t2 = big_sigma0(st_in[0]) + maj(st_in[0], st_in[1], st_in[2]);
        st_out[0] = t1 + t2;
        st_out[1] = st_in[0];
        st_out[2] = st_in[1];
        st_out[3] = st_in[2];
        st_out[4] = st_in[3] + t1;
        st_out[5] = st_in[4];
        st_out[6] = st_in[5];
        st_out[7] = st_in[6];
    end

endmodule

// File: rtl/sha256_block_acc.sv
// rtl/sha256_block_acc.sv - memory-mapped single-block SHA-256 compression with digest streaming
//   clk, reset (async, active-low)
//   chipselect/write/address/writedata : register bus; 0-15 message words, 16 control (bit0 = start)
//   data_out      : current digest word
//   writeaddress  : {valid, 5'b0, word index}, all zero outside the digest stream
module sha256_block_acc
    import sha256_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic        chipselect,
    input  logic        write,
    input  logic [4:0]  address,
    input  logic [31:0] writedata,
    output logic [31:0] data_out,
    output logic [8:0]  writeaddress
);

    state_t      state_q;
    state_t      state_d;

    logic [31:0] msg_q    [0:15];
    logic [31:0] win_q    [0:15];
    logic [31:0] work_q   [0:7];
    logic [31:0] digest_q [0:7];
    logic [31:0] round_st [0:7];
    logic [5:0]  rnd_q;
    logic [2:0]  out_idx_q;
    logic [2:0]  out_nxt;
    logic [31:0] sched_new;

    logic wr_en;
    logic accepting;
    logic start_req;

    assign wr_en     = chipselect && write;
    assign accepting = (state_q == S_IDLE) || (state_q == S_DONE);
    assign start_req = wr_en && (address == 5'd16) && writedata[0];
    assign out_nxt   = out_idx_q + 3'd1;

    // win_q[0] is always W[t]; the new tail word is W[t+16].
    assign sched_new = small_sigma1(win_q[14]) + win_q[9] + small_sigma0(win_q[1]) + win_q[0];

    sha256_round u_round (
        .st_in  (work_q),
        .k      (K[rnd_q]),
        .w      (win_q[0]),
        .st_out (round_st)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (start_req) state_d = S_LOAD;
            S_LOAD:  state_d = S_ROUND;
            S_ROUND: if (rnd_q == 6'd63) state_d = S_FINAL;
            S_FINAL: state_d = S_OUT;
            S_OUT:   if (out_idx_q == 3'd7) state_d = S_DONE;
            S_DONE:  if (start_req) state_d = S_LOAD;
            default: state_d = S_IDLE;
        endcase
    end

    // Outputs are registered one cycle ahead: FINAL presents H0, each OUT
    // cycle presents the next word, and the last OUT cycle drops valid.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 16; i++) begin
                msg_q[i] <= '0;
                win_q[i] <= '0;
            end
            for (int i = 0; i < 8; i++) begin
                work_q[i]   <= '0;
                digest_q[i] <= '0;
            end
            rnd_q        <= '0;
            out_idx_q    <= '0;
            data_out     <= '0;
            writeaddress <= '0;
        end else begin
            if (accepting && wr_en && !address[4]) begin
                msg_q[address[3:0]] <= writedata;
            end
            case (state_q)
                S_LOAD: begin
                    for (int i = 0; i < 8; i++) work_q[i] <= IV[i];
                    for (int i = 0; i < 16; i++) win_q[i] <= msg_q[i];
                    rnd_q <= '0;
                end
                S_ROUND: begin
                    for (int i = 0; i < 8; i++) work_q[i] <= round_st[i];
                    for (int i = 0; i < 15; i++) win_q[i] <= win_q[i + 1];
                    win_q[15] <= sched_new;
                    rnd_q     <= rnd_q + 6'd1;
                end
                S_FINAL: begin
                    for (int i = 0; i < 8; i++) digest_q[i] <= IV[i] + work_q[i];
                    data_out     <= IV[0] + work_q[0];
                    writeaddress <= 9'h100;
                    out_idx_q    <= '0;
                end
                S_OUT: begin
                    out_idx_q <= out_nxt;
                    if (out_idx_q == 3'd7) begin
                        writeaddress <= '0;
                    end else begin
                        data_out     <= digest_q[out_nxt];
                        writeaddress <= {1'b1, 5'b00000, out_nxt};
                    end
                end
                default: begin
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sha256_block_acc.sv
// tb/tb_sha256_block_acc.sv - self-checking bench for sha256_block_acc against a behavioural SHA-256 model
module tb_sha256_block_acc;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        chipselect = 1'b0;
    logic        write = 1'b0;
    logic [4:0]  address = '0;
    logic [31:0] writedata = '0;
    logic [31:0] data_out;
    logic [8:0]  writeaddress;

    sha256_block_acc dut (
        .clk          (clk),
        .reset        (rst_n),
        .chipselect   (chipselect),
        .write        (write),
        .address      (address),
        .writedata    (writedata),
        .data_out     (data_out),
        .writeaddress (writeaddress)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_mis = 0;
    int c0 = 0;
    int last_wr_cyc = 0;

    logic [31:0] kk [64];
    logic [31:0] iv [8];
    logic [31:0] blk [16];
    logic [31:0] exp_h [8];
    logic [31:0] got_h [8];
    logic [31:0] abc_h [8];
    logic [31:0] saved_h [8];
    logic [31:0] vec [16];

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_mis++;
            $display("FAIL %s: got %08h expected %08h", tag, got, exp);
        end
    endtask

    // Constants derived from first principles: fractional parts of square
    // roots (IV) and cube roots (K) of the leading primes.
    function automatic logic [31:0] frac_bits(input real x);
        real f;
        logic [63:0] v;
        f = x - $floor(x);
        v = longint'($floor(f * 4294967296.0));
        return v[31:0];
    endfunction

    function automatic bit is_prime(input int p);
        for (int d = 2; d * d <= p; d++) if (p % d == 0) return 1'b0;
        return 1'b1;
    endfunction

    task automatic build_constants();
        int p;
        p = 2;
        for (int n = 0; n < 64; n++) begin
            while (!is_prime(p)) p++;
            kk[n] = frac_bits($pow(real'(p), 1.0 / 3.0));
            if (n < 8) iv[n] = frac_bits($sqrt(real'(p)));
            p++;
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    task automatic ref_hash();
        logic [31:0] w [64];
        logic [31:0] v [8];
        logic [31:0] t1, t2, s0, s1;
        for (int t = 0; t < 16; t++) w[t] = blk[t];
        for (int t = 16; t < 64; t++) begin
            s0 = rotr(w[t-15], 7) ^ rotr(w[t-15], 18) ^ (w[t-15] >> 3);
            s1 = rotr(w[t-2], 17) ^ rotr(w[t-2], 19) ^ (w[t-2] >> 10);
            w[t] = s1 + w[t-7] + s0 + w[t-16];
        end
        for (int i = 0; i < 8; i++) v[i] = iv[i];
        for (int t = 0; t < 64; t++) begin
            t1 = v[7] + (rotr(v[4], 6) ^ rotr(v[4], 11) ^ rotr(v[4], 25))
                 + ((v[4] & v[5]) ^ (~v[4] & v[6])) + kk[t] + w[t];
            t2 = (rotr(v[0], 2) ^ rotr(v[0], 13) ^ rotr(v[0], 22))
                 + ((v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]));
            for (int i = 7; i > 0; i--) v[i] = v[i-1];
            v[4] = v[4] + t1;
            v[0] = t1 + t2;
        end
        for (int i = 0; i < 8; i++) exp_h[i] = iv[i] + v[i];
    endtask

    task automatic bus_write(input logic [4:0] a, input logic [31:0] d, input logic cs);
        @(negedge clk);
        chipselect  = cs;
        write       = 1'b1;
        address     = a;
        writedata   = d;
        last_wr_cyc = cyc;
        @(negedge clk);
        chipselect  = 1'b0;
        write       = 1'b0;
    endtask

    task automatic write_block();
        for (int i = 0; i < 16; i++) bus_write(5'(i), blk[i], 1'b1);
    endtask

    task automatic start_hash();
        bus_write(5'd16, $urandom | 32'h1, 1'b1);
        c0 = last_wr_cyc;
    endtask

    task automatic expect_digest(input string tag);
        while (writeaddress[8] !== 1'b1 && (cyc - c0) < 150) @(negedge clk);
        check($sformatf("%s_latency", tag), 32'(cyc - c0), 32'd67);
        for (int k = 0; k < 8; k++) begin
            got_h[k] = data_out;
            check($sformatf("%s_wa%0d", tag, k), {23'b0, writeaddress}, {23'b0, 1'b1, 5'b0, 3'(k)});
            check($sformatf("%s_h%0d", tag, k), data_out, exp_h[k]);
            @(negedge clk);
        end
        check($sformatf("%s_wa_end", tag), {23'b0, writeaddress}, 32'd0);
        check($sformatf("%s_hold", tag), data_out, exp_h[7]);
    endtask

    initial begin
        int bad;
        build_constants();
        vec = '{32'h01000000, 32'h9500c43a, 32'h25c62452, 32'h0b5100ad,
                32'hf82cb9f9, 32'hda72fd24, 32'h47a496bc, 32'h600b0000,
                32'h00000000, 32'h6cd86237, 32'h0395dedf, 32'h1da2841c,
                32'hcda0fc48, 32'h9e3039de, 32'h5f1ccdde, 32'hf0e83499};
        abc_h = '{32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
                  32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad};

        // Reset state
        repeat (2) @(negedge clk);
        check("rst_data", data_out, 32'd0);
        check("rst_wa", {23'b0, writeaddress}, 32'd0);
        rst_n = 1'b1;

        // Known-answer block: "abc" padded
        for (int i = 0; i < 16; i++) blk[i] = '0;
        blk[0]  = 32'h61626380;
        blk[15] = 32'h00000018;
        ref_hash();
        for (int i = 0; i < 8; i++) check($sformatf("kat_model%0d", i), exp_h[i], abc_h[i]);
        write_block();
        start_hash();
        expect_digest("abc");
        for (int i = 0; i < 8; i++) check($sformatf("kat_dut%0d", i), got_h[i], abc_h[i]);

        // Mining header vector
        for (int i = 0; i < 16; i++) blk[i] = vec[i];
        ref_hash();
        write_block();
        start_hash();
        expect_digest("vec");
        for (int i = 0; i < 8; i++) saved_h[i] = exp_h[i];

        // Busy protection: message and start writes during rounds are ignored
        start_hash();
        repeat (10) @(negedge clk);
        bus_write(5'd0, $urandom, 1'b1);
        bus_write(5'd16, 32'h1, 1'b1);
        expect_digest("busy");

        // Re-start with no new writes; chipselect-low write must not land either
        bus_write(5'd0, $urandom, 1'b0);
        start_hash();
        expect_digest("restart");

        // Starts that must be ignored
        bus_write(5'd16, 32'h1, 1'b0);
        bus_write(5'd16, 32'hfffffffe, 1'b1);
        bus_write(5'd20, 32'hffffffff, 1'b1);
        bad = 0;
        for (int i = 0; i < 80; i++) begin
            if (writeaddress !== 9'h000) bad++;
            @(negedge clk);
        end
        check("no_start_wa", 32'(bad), 32'd0);
        check("no_start_hold", data_out, saved_h[7]);

        // Randomized blocks
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < 16; i++) blk[i] = $urandom;
            ref_hash();
            write_block();
            start_hash();
            expect_digest($sformatf("rnd%0d", r));
        end

        // Reset mid-round clears outputs and the stored block
        start_hash();
        repeat (20) @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("midrst_data", data_out, 32'd0);
        check("midrst_wa", {23'b0, writeaddress}, 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        for (int i = 0; i < 16; i++) blk[i] = '0;
        ref_hash();
        start_hash();
        expect_digest("zero");
        for (int i = 0; i < 16; i++) blk[i] = $urandom;
        ref_hash();
        write_block();
        start_hash();
        expect_digest("post_rst");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
        $finish;
    end

endmodule
